// File: rtl/lpddr_pkg.sv
// Shared constants and enums for the LPDDR AXI performance monitor.
package lpddr_pkg;

  localparam int LPDDR_PERF_NUM_EVT       = 4;
  localparam int LPDDR_PERF_COUNTER_WIDTH = 32;

  typedef enum logic [1:0] {
    EVT_AW = 2'd0,
    EVT_W  = 2'd1,
    EVT_AR = 2'd2,
    EVT_R  = 2'd3
  } lpddr_evt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLOSE = 2'd2
  } lpddr_perf_state_e;

endpackage

// File: rtl/lpddr_perf_cnt.sv
// Single event counter: clear, load-zero-plus-increment, saturating or wrapping
// increment, and a sticky overflow flag.
module lpddr_perf_cnt
  import lpddr_pkg::*;
#(
  parameter int CntW = LPDDR_PERF_COUNTER_WIDTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clear,
  input  logic            i_inc,
  input  logic            i_load,
  input  logic            i_sat_mode,
  output logic [CntW-1:0] o_cnt,
  output logic            o_ovf
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (i_clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (i_load) begin
      // Window restart: the event seen in this cycle belongs to the new window.
      cnt_d = {{(CntW-1){1'b0}}, i_inc};
    end else if (i_inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = i_sat_mode ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_ovf = ovf_q;

endmodule

// File: rtl/lpddr_axi_perf_mon.sv
// Windowed AXI handshake counters per port plus a cycle counter; each window
// close copies the live counters into readable shadow registers.
module lpddr_axi_perf_mon
  import lpddr_pkg::*;
#(
  parameter  int NumPorts = 2,
  parameter  int CntW     = LPDDR_PERF_COUNTER_WIDTH,
  parameter  int WinW     = 32,
  localparam int NumCnt   = NumPorts * LPDDR_PERF_NUM_EVT + 1,
  localparam int SelW     = $clog2(NumCnt)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_clear,
  input  logic                i_snapshot,
  input  logic                i_sat_mode,
  input  logic [WinW-1:0]     i_window_len,
  input  logic [NumPorts-1:0] i_aw_hs,
  input  logic [NumPorts-1:0] i_w_hs,
  input  logic [NumPorts-1:0] i_ar_hs,
  input  logic [NumPorts-1:0] i_r_hs,
  input  logic [SelW-1:0]     i_rd_sel,
  output logic [CntW-1:0]     o_rd_data,
  output logic                o_snap_valid,
  output logic [NumCnt-1:0]   o_ovf,
  output logic                o_busy
);

  lpddr_perf_state_e state_q, state_d;
  logic [WinW-1:0]   win_q, win_d;
  logic              close_hit;
  logic              snap_q, busy_q;
  logic [CntW-1:0]   rd_data_q, rd_data_d;
  logic [CntW-1:0]   shadow_q [NumCnt];
  logic [CntW-1:0]   shadow_d [NumCnt];
  logic [CntW-1:0]   live_cnt [NumCnt];
  logic [NumCnt-1:0] inc_vec;
  logic              counting, load_live;

  assign counting  = (state_q != ST_IDLE);
  assign load_live = (state_q == ST_CLOSE);

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    assign inc_vec[gi*LPDDR_PERF_NUM_EVT + int'(EVT_AW)] = counting & i_aw_hs[gi];
    assign inc_vec[gi*LPDDR_PERF_NUM_EVT + int'(EVT_W)]  = counting & i_w_hs[gi];
    assign inc_vec[gi*LPDDR_PERF_NUM_EVT + int'(EVT_AR)] = counting & i_ar_hs[gi];
    assign inc_vec[gi*LPDDR_PERF_NUM_EVT + int'(EVT_R)]  = counting & i_r_hs[gi];
  end
  assign inc_vec[NumCnt-1] = counting;

  for (genvar gi = 0; gi < NumCnt; gi++) begin : g_cnt
    lpddr_perf_cnt #(.CntW(CntW)) u_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clear    (i_clear),
      .i_inc      (inc_vec[gi]),
      .i_load     (load_live),
      .i_sat_mode (i_sat_mode),
      .o_cnt      (live_cnt[gi]),
      .o_ovf      (o_ovf[gi])
    );
  end

  // win_q is the index of the current cycle inside the window; the CLOSE cycle
  // is index 0 of the next window, so every window spans i_window_len cycles.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    close_hit = (i_window_len != '0) && (win_q == i_window_len - WinW'(1));
    case (state_q)
      ST_IDLE: begin
        if (i_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        win_d = win_q + WinW'(1);
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (i_snapshot || close_hit) begin
          state_d = ST_CLOSE;
          win_d   = '0;
        end
      end
      ST_CLOSE: begin
        win_d   = WinW'(1);
        state_d = i_enable ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_clear) begin
      win_d   = '0;
      state_d = (state_q == ST_CLOSE) ? ST_RUN : state_q;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (i_clear) begin
      shadow_d = '{default: '0};
    end else if (load_live) begin
      shadow_d = live_cnt;
    end
    rd_data_d = '0;
    if (int'(i_rd_sel) < NumCnt) rd_data_d = shadow_q[i_rd_sel];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      snap_q    <= 1'b0;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
      shadow_q  <= '{default: '0};
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      snap_q    <= (state_d == ST_CLOSE);
      busy_q    <= (state_d == ST_RUN);
      rd_data_q <= rd_data_d;
      shadow_q  <= shadow_d;
    end
  end

  assign o_rd_data    = rd_data_q;
  assign o_snap_valid = snap_q;
  assign o_busy       = busy_q;

endmodule

// File: doc/lpddr_axi_perf_mon.md
LPDDR_AXI_PERF_MON -- requirements
Module: lpddr_axi_perf_mon

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of monitored AXI target ports (1..8).
REQ-002 SHALL have parameter CntW, default 32 (lpddr_pkg::LPDDR_PERF_COUNTER_WIDTH): width of every counter.
REQ-003 SHALL have parameter WinW, default 32: window-length field width.
REQ-004 i_clk  in  1  single clock for all logic.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_enable  in  1  level; 1 = counting.
REQ-007 i_clear  in  1  pulse; zeroes all counters, shadows and flags.
REQ-008 i_snapshot  in  1  pulse; manual window close.
REQ-009 i_sat_mode  in  1  1 = saturate, 0 = wrap.
REQ-010 i_window_len  in  WinW  auto-window length in cycles; 0 = no auto-window.
REQ-011 i_aw_hs, i_w_hs, i_ar_hs, i_r_hs  in  NumPorts each  per-port valid&&ready handshake strobes.
REQ-012 i_rd_sel  in  $clog2(NumPorts*4+1)  shadow-counter select.
REQ-013 o_rd_data  out  CntW  selected shadow counter.
REQ-014 o_snap_valid  out  1  one-cycle pulse on each window close.
REQ-015 o_ovf  out  NumPorts*4+1  sticky overflow flag per counter.
REQ-016 o_busy  out  1  1 while FSM in RUN.

Function
REQ-017 Live counters SHALL be, per port p, index p*4+{0:AW,1:W,2:AR,3:R}; index NumPorts*4 is the global cycle counter.
REQ-018 FSM states SHALL be IDLE, RUN, CLOSE.
REQ-019 IDLE -> RUN when i_enable=1; RUN -> IDLE when i_enable=0 (live counters hold value); CLOSE -> RUN unconditionally after one cycle, or -> IDLE if i_enable=0.
REQ-020 RUN -> CLOSE when i_snapshot=1, or when i_window_len!=0 and window count equals i_window_len-1.
REQ-021 In RUN, each event counter SHALL increment by 1 on its strobe; the cycle counter SHALL increment every cycle.
REQ-022 In CLOSE, live counters SHALL be copied to shadows, live counters reset to the increment of that cycle (0 or 1), window count reset to 0, and o_snap_valid asserted for that cycle.
REQ-023 Shadows SHALL therefore show the window ending at the cycle before CLOSE; no event SHALL be lost or double-counted across a window boundary.
REQ-024 In IDLE, strobes and i_snapshot SHALL be ignored.
REQ-025 On increment at all-ones: wrap mode -> 0; saturate mode -> hold all-ones; in both, set the counter's o_ovf bit (sticky until i_clear or reset).
REQ-026 i_clear SHALL take priority over every other event: all live, shadow, window and ovf state zeroed the next cycle, FSM state unchanged except CLOSE -> RUN, no o_snap_valid.
REQ-027 o_rd_data SHALL be registered: value of shadow[i_rd_sel] one cycle after i_rd_sel is applied; sel > NumPorts*4 returns 0.
REQ-028 i_window_len changes SHALL take effect at the next window count comparison; if the new length <= current window count, close on count wrap only (no spurious early close).

Reset
REQ-029 On i_rst all counters, shadows, o_ovf, o_rd_data, o_snap_valid, o_busy SHALL be 0; FSM in IDLE.
REQ-030 Reset asserted mid-window SHALL discard the window; no o_snap_valid on reset release.

Structure
REQ-031 lpddr_pkg SHALL hold: LPDDR_PERF_NUM_EVT = 4, event-index enum (AW, W, AR, R), FSM state enum, and CntW default.
REQ-032 A sub-module lpddr_perf_cnt SHALL implement one counter (inc, clear, load-zero-plus-inc, sat/wrap, ovf) and be instantiated NumPorts*4+1 times.
REQ-033 Handshake strobes SHALL be assumed synchronous to i_clk; no synchroniser inside.

Verification
REQ-034 Enable, 10 AW strobes port 0, manual snapshot -> o_snap_valid 1 cycle, rd_sel 0 returns 10 next cycle, other event counters 0.
REQ-035 window_len=100, continuous R strobes port 1 -> o_snap_valid every 100 cycles, shadow index 7 = 100, cycle counter = 100 each window.
REQ-036 CntW=8, sat_mode=1, 300 W strobes -> shadow 255, ovf bit 1 set; sat_mode=0 -> shadow 44, ovf set.
REQ-037 AR strobe coincident with CLOSE cycle -> counted in next window (new window shadow = 1 with no other strobes).
REQ-038 i_clear and i_snapshot same cycle -> no o_snap_valid, all shadows and ovf 0.
REQ-039 i_rst asserted mid-window after 50 events -> all outputs 0 asynchronously, IDLE, no o_snap_valid after release.
